jk_cmd_sequencer: RTL and testbench

Command sequencer that drives the J/K inputs of a `jk_flipflop` and self-checks its output. It accepts hold/reset/set/toggle commands over a valid/ready handshake and buffers them in a small FIFO. It issues each command as a one-cycle J/K pulse, then compares the flip-flop's `q` against a shadow model and reports mismatches. It sits directly upstream of `jk_flipflop` and consumes that block's `q`.

---
 rtl/jk_cmd_sequencer.sv | 140 ++++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues hold/reset/set/toggle commands and issues each one as a
// one-cycle J/K pulse to a downstream jk_flipflop. It then checks the flop's q
// against a shadow model and counts completed commands and mismatches.
// Latency: accept at edge N, pop at N+1, flop capture at N+2, check at N+3.
// Backpressure: cmd_ready drops while the FIFO is full or rst is high.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  output logic       j,
  output logic       k,
  input  logic       q,
  output logic       busy,
  output logic       err,
  output logic [7:0] err_count,
  output logic [7:0] done_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    head;
  logic          q_exp;
  logic          known;
  logic          full;
  logic          push;
  logic          pop;

  // ready comes from the registered count, so a same-edge pop never raises it early
  assign full      = (count == (AW+1)'(DEPTH));
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || (count != '0);

  // FIFO storage: data needs no reset, occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd;
    end
  end

  // FIFO pointers and occupancy; reset discards all queued commands
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // issue/check FSM with the shadow model and the status counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      j          <= 1'b0;
      k          <= 1'b0;
      q_exp      <= 1'b0;
      known      <= 1'b0;
      err        <= 1'b0;
      err_count  <= 8'd0;
      done_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            j     <= head[1];
            k     <= head[0];
            state <= DRIVE;
            // the shadow model commits here and is compared in CHECK
            case (head)
              2'b10: begin
                q_exp <= 1'b1;
                known <= 1'b1;
              end
              2'b01: begin
                q_exp <= 1'b0;
                known <= 1'b1;
              end
              2'b11:   q_exp <= ~q_exp;
              default: q_exp <= q_exp;
            endcase
          end else begin
            j <= 1'b0;
            k <= 1'b0;
          end
        end
        DRIVE: begin
          // the flop samples the pulse at this edge
          j     <= 1'b0;
          k     <= 1'b0;
          state <= CHECK;
        end
        CHECK: begin
          if (known && (q != q_exp)) begin
            err <= 1'b1;
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end
          done_count <= done_count + 8'd1;
          state      <= IDLE;
        end
        default: begin
          j     <= 1'b0;
          k     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: a behavioural J/K flop closes the loop, and a
// vector table plus directed sequences cover ordering, throughput, full FIFO,
// the unknown state, a stuck output and reset while a command is in flight.
module tb_jk_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       cmd_ready;
  logic       j;
  logic       k;
  logic       q;
  logic       busy;
  logic       err;
  logic [7:0] err_count;
  logic [7:0] done_count;

  // behavioural flop: preloadable, and its output can be forced stuck at 0
  logic q_ff;
  logic ff_load = 1'b0;
  logic ff_val = 1'b0;
  logic stuck = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0] cmd;
    logic       exp_j;
    logic       exp_k;
    logic       exp_q;
    logic       exp_err;
    logic [7:0] exp_errc;
    logic [7:0] exp_done;
  } vec_t;

  vec_t tbl [8];

  jk_cmd_sequencer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .j          (j),
    .k          (k),
    .q          (q),
    .busy       (busy),
    .err        (err),
    .err_count  (err_count),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ff_load) begin
      q_ff <= ff_val;
    end else begin
      case ({j, k})
        2'b01:   q_ff <= 1'b0;
        2'b10:   q_ff <= 1'b1;
        2'b11:   q_ff <= ~q_ff;
        default: q_ff <= q_ff;
      endcase
    end
  end

  assign q = stuck ? 1'b0 : q_ff;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reset with the flop preloaded to qv, then check the reset state
  task automatic do_reset(input logic qv);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    ff_load   = 1'b1;
    ff_val    = qv;
    tick;
    ff_load = 1'b0;
    tick;
    chk("rst_ready", {7'd0, cmd_ready}, 8'd0);
    chk("rst_jk", {6'd0, j, k}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    chk("rst_errc", err_count, 8'd0);
    chk("rst_done", done_count, 8'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", {7'd0, cmd_ready}, 8'd1);
  endtask

  // one isolated command: accept, pulse, flop capture, check
  task automatic run_vec(input vec_t v, input string nm);
    cmd_valid = 1'b1;
    cmd       = v.cmd;
    tick;
    cmd_valid = 1'b0;
    tick;
    chk({nm, "_jk_pulse"}, {6'd0, j, k}, {6'd0, v.exp_j, v.exp_k});
    tick;
    chk({nm, "_jk_after"}, {6'd0, j, k}, 8'd0);
    chk({nm, "_q"}, {7'd0, q}, {7'd0, v.exp_q});
    tick;
    chk({nm, "_err"}, {7'd0, err}, {7'd0, v.exp_err});
    chk({nm, "_errc"}, err_count, v.exp_errc);
    chk({nm, "_done"}, done_count, v.exp_done);
    chk({nm, "_busy"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    logic [1:0] seq_a [4];
    logic [1:0] seq_c [8];
    logic [7:0] exp_jk;
    vec_t       v;
    int         idx;
    int         pidx;
    int         m_cnt;
    int         m_st;
    logic       m_push;
    logic       m_pop;

    //            cmd    j     k     q     err   errc   done
    tbl[0] = '{2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1};
    tbl[1] = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2};
    tbl[2] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd3};
    tbl[3] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd4};
    tbl[4] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd5};
    tbl[5] = '{2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd6};
    tbl[6] = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd7};
    tbl[7] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd8};

    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // back-to-back set, reset, toggle, toggle: pulses 3 cycles apart
    do_reset(1'b0);
    seq_a[0] = 2'b10;
    seq_a[1] = 2'b01;
    seq_a[2] = 2'b11;
    seq_a[3] = 2'b11;
    for (int i = 0; i < 14; i++) begin
      cmd_valid = (i < 4);
      cmd       = (i < 4) ? seq_a[i] : 2'b00;
      tick;
      case (i)
        1:       exp_jk = 8'd2;
        4:       exp_jk = 8'd1;
        7, 10:   exp_jk = 8'd3;
        default: exp_jk = 8'd0;
      endcase
      chk($sformatf("b2b_jk_c%0d", i), {6'd0, j, k}, exp_jk);
      if (i == 2 || i == 8) chk($sformatf("b2b_q_c%0d", i), {7'd0, q}, 8'd1);
      if (i == 5 || i == 11) chk($sformatf("b2b_q_c%0d", i), {7'd0, q}, 8'd0);
    end
    chk("b2b_err", {7'd0, err}, 8'd0);
    chk("b2b_done", done_count, 8'd4);

    // unknown state: flop preloaded to 1, so a checked toggle would mismatch
    do_reset(1'b1);
    v = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1};
    run_vec(v, "unk_toggle");
    v = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd2};
    run_vec(v, "unk_hold");
    v = '{2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd3};
    run_vec(v, "unk_set");

    // stuck-at-0 output: err is sticky through later passing commands
    stuck = 1'b1;
    v = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd4};
    run_vec(v, "stuck_set");
    stuck = 1'b0;
    v = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 8'd5};
    run_vec(v, "sticky_reset");
    v = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 8'd6};
    run_vec(v, "sticky_toggle");
    do_reset(1'b0);

    // full FIFO: cmd_valid held for 8 commands against a cycle model
    seq_c[0] = 2'b10; seq_c[1] = 2'b01; seq_c[2] = 2'b11; seq_c[3] = 2'b00;
    seq_c[4] = 2'b11; seq_c[5] = 2'b10; seq_c[6] = 2'b00; seq_c[7] = 2'b01;
    idx = 0;
    pidx = 0;
    m_cnt = 0;
    m_st = 0;
    cmd_valid = 1'b1;
    cmd = seq_c[0];
    for (int c = 0; c < 32; c++) begin
      chk($sformatf("fill_ready_c%0d", c), {7'd0, cmd_ready}, {7'd0, (m_cnt != 4)});
      m_push = cmd_valid && (m_cnt < 4);
      m_pop  = (m_st == 0) && (m_cnt > 0);
      tick;
      m_cnt = m_cnt + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
      if (m_push) idx++;
      case (m_st)
        0:       m_st = m_pop ? 1 : 0;
        1:       m_st = 2;
        default: m_st = 0;
      endcase
      if (m_st == 1 && pidx < 8) begin
        chk($sformatf("fill_issue%0d", pidx), {6'd0, j, k}, {6'd0, seq_c[pidx]});
        pidx++;
      end else begin
        chk($sformatf("fill_idle_jk_c%0d", c), {6'd0, j, k}, 8'd0);
      end
      cmd_valid = (idx < 8);
      cmd       = (idx < 8) ? seq_c[idx] : 2'b00;
    end
    chk("fill_done", done_count, 8'd8);
    chk("fill_err", {7'd0, err}, 8'd0);
    chk("fill_busy", {7'd0, busy}, 8'd0);

    // reset during DRIVE of a set with reset and toggle still queued
    do_reset(1'b0);
    cmd_valid = 1'b1;
    cmd = 2'b00;
    tick;
    cmd = 2'b10;
    tick;
    cmd = 2'b01;
    tick;
    cmd = 2'b11;
    tick;
    cmd_valid = 1'b0;
    tick;
    chk("mid_drive_jk", {6'd0, j, k}, 8'd2);
    chk("mid_busy_pre", {7'd0, busy}, 8'd1);
    chk("mid_done_pre", done_count, 8'd1);
    rst = 1'b1;
    tick;
    chk("mid_jk", {6'd0, j, k}, 8'd0);
    chk("mid_busy", {7'd0, busy}, 8'd0);
    chk("mid_done", done_count, 8'd0);
    chk("mid_errc", err_count, 8'd0);
    chk("mid_ready_rst", {7'd0, cmd_ready}, 8'd0);
    rst = 1'b0;
    #1;
    chk("mid_ready_rel", {7'd0, cmd_ready}, 8'd1);
    for (int c = 0; c < 10; c++) begin
      tick;
      chk($sformatf("mid_quiet_jk_c%0d", c), {6'd0, j, k}, 8'd0);
      chk($sformatf("mid_quiet_busy_c%0d", c), {7'd0, busy}, 8'd0);
    end
    chk("mid_done_final", done_count, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
